// File: rtl/fft_pkg.sv
// Shared complex-sample helpers for the streaming FFT stages.
// Parts are packed {re, im}; arithmetic wraps independently per part.
package fft_pkg;

    localparam int CPLX_MAX = 128;
    typedef logic [CPLX_MAX-1:0] cplx_wide_t;

    function automatic int cplx_width(input int re_w, input int im_w);
        return re_w + im_w;
    endfunction

    function automatic cplx_wide_t part_mask(input int w);
        return (cplx_wide_t'(1) << w) - cplx_wide_t'(1);
    endfunction

    function automatic cplx_wide_t cplx_re(input cplx_wide_t x, input int re_w, input int im_w);
        return (x >> im_w) & part_mask(re_w);
    endfunction

    function automatic cplx_wide_t cplx_im(input cplx_wide_t x, input int im_w);
        return x & part_mask(im_w);
    endfunction

    function automatic cplx_wide_t cplx_pack(input cplx_wide_t re, input cplx_wide_t im,
                                             input int re_w, input int im_w);
        return ((re & part_mask(re_w)) << im_w) | (im & part_mask(im_w));
    endfunction

    // Masking after the wide add/sub gives two's-complement wrap modulo 2^width.
    function automatic cplx_wide_t cplx_add(input cplx_wide_t a, input cplx_wide_t b,
                                            input int re_w, input int im_w);
        return cplx_pack(cplx_re(a, re_w, im_w) + cplx_re(b, re_w, im_w),
                         cplx_im(a, im_w) + cplx_im(b, im_w), re_w, im_w);
    endfunction

    function automatic cplx_wide_t cplx_sub(input cplx_wide_t a, input cplx_wide_t b,
                                            input int re_w, input int im_w);
        return cplx_pack(cplx_re(a, re_w, im_w) - cplx_re(b, re_w, im_w),
                         cplx_im(a, im_w) - cplx_im(b, im_w), re_w, im_w);
    endfunction

endpackage

// File: rtl/fft_r2sdf_stage_if.sv
// Sample stream into and out of one R2SDF stage.
interface fft_r2sdf_stage_if #(parameter int CPLX_WIDTH = 36);
    logic                  in_valid;
    logic [CPLX_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic [CPLX_WIDTH-1:0] out_data;
    logic                  out_first;

    modport master (output in_valid, output in_data,
                    input  out_valid, input out_data, input out_first);
    modport slave  (input  in_valid, input in_data,
                    output out_valid, output out_data, output out_first);
endinterface

// File: rtl/sdf_delay_line.sv
// Enable-gated shift-register FIFO; no reset so it can map to SRL/BRAM.
module sdf_delay_line #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [DEPTH-1:0][WIDTH-1:0] mem;

    // New entries enter at the top; entry 0 is the oldest.
    always_ff @(posedge clk)
        if (en) mem <= {din, mem[DEPTH-1:1]};

    assign dout = mem[0];
endmodule

// File: rtl/fft_r2sdf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage: sums of each block,
// then its differences, as one serial stream.
module fft_r2sdf_stage
    import fft_pkg::*;
#(
    parameter int REAL_WIDTH = 18,
    parameter int IMGN_WIDTH = 18,
    parameter int DEPTH      = 8
) (
    input  logic              clk,
    input  logic              rst,
    fft_r2sdf_stage_if.slave  bus
);
    localparam int CPLX_WIDTH = cplx_width(REAL_WIDTH, IMGN_WIDTH);
    localparam int CW         = $clog2(2 * DEPTH);

    logic [CW-1:0]         cnt;
    logic                  primed;
    logic                  phase;
    logic [CPLX_WIDTH-1:0] head, sum, diff, push;

    assign phase = cnt[CW-1];
    assign sum   = CPLX_WIDTH'(cplx_add(cplx_wide_t'(head), cplx_wide_t'(bus.in_data),
                                        REAL_WIDTH, IMGN_WIDTH));
    assign diff  = CPLX_WIDTH'(cplx_sub(cplx_wide_t'(head), cplx_wide_t'(bus.in_data),
                                        REAL_WIDTH, IMGN_WIDTH));
    // Feedback: during the butterfly half the difference replaces the consumed sample.
    assign push  = phase ? diff : bus.in_data;

    sdf_delay_line #(.WIDTH(CPLX_WIDTH), .DEPTH(DEPTH)) u_dly (
        .clk  (clk),
        .en   (bus.in_valid && !rst),
        .din  (push),
        .dout (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            primed        <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_first <= 1'b0;
        end else if (bus.in_valid) begin
            cnt <= cnt + 1'b1;
            if (!phase) begin
                // Head holds the previous block's difference; only real once primed.
                bus.out_data  <= head;
                bus.out_valid <= primed;
                bus.out_first <= 1'b0;
            end else begin
                bus.out_data  <= sum;
                bus.out_valid <= 1'b1;
                bus.out_first <= (cnt == CW'(DEPTH));
                primed        <= 1'b1;
            end
        end else begin
            bus.out_valid <= 1'b0;
            bus.out_first <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fft_r2sdf_stage.sv
// Directed bench for fft_r2sdf_stage at DEPTH=4, 18/18-bit parts.
module tb_fft_r2sdf_stage;
    localparam int RW = 18, IW = 18, D = 4, CW = RW + IW;

    typedef struct {
        logic [CW-1:0] data;
        logic          first;
        int            cyc;
    } cap_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_acc;
    cap_t cap_q[$];

    fft_r2sdf_stage_if #(.CPLX_WIDTH(CW)) bus ();

    fft_r2sdf_stage #(.REAL_WIDTH(RW), .IMGN_WIDTH(IW), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (bus.out_valid === 1'b1)
            cap_q.push_back('{data: bus.out_data, first: bus.out_first, cyc: cyc});
    end

    function automatic int f_re(input logic [CW-1:0] d);
        logic signed [RW-1:0] r;
        r = d[CW-1:IW];
        return int'(r);
    endfunction

    function automatic int f_im(input logic [CW-1:0] d);
        logic signed [IW-1:0] m;
        m = d[IW-1:0];
        return int'(m);
    endfunction

    task automatic feed(input int re, input int im);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = {RW'(re), IW'(im)};
        @(posedge clk);
        #1;
        last_acc = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_data  = '0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cap_q.delete();
    endtask

    task automatic pop(output logic got, output cap_t c);
        got = 1'b0;
        c   = '{data: '0, first: 1'b0, cyc: 0};
        if (cap_q.size() > 0) begin
            c   = cap_q.pop_front();
            got = 1'b1;
        end
    endtask

    task automatic test_reset;
        do_reset;
        for (int i = 0; i < 6; i++) feed(i + 1, 3);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = {RW'(7), IW'(7)};
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.out_data); end
        checks++; if (bus.out_first !== 1'b0) begin errors++; $display("FAIL reset_first: got %b expected 0", bus.out_first); end
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        cap_q.delete();
        for (int i = 0; i < 4; i++) feed(0, 0);
        idle(1);
        checks++; if (cap_q.size() != 0) begin errors++; $display("FAIL reset_unprimed: got %0d outputs expected 0", cap_q.size()); end
    endtask

    task automatic test_basic;
        int   exp_re[8] = '{6, 8, 10, 12, -4, -4, -4, -4};
        int   acc5 = 0;
        int   prev = 0;
        cap_t c;
        logic got;
        do_reset;
        for (int i = 0; i < 8; i++) begin
            feed(i + 1, 0);
            if (i == 4) acc5 = last_acc;
        end
        for (int i = 0; i < 4; i++) feed(0, 0);
        idle(2);
        checks++; if (cap_q.size() != 8) begin errors++; $display("FAIL basic_count: got %0d expected 8", cap_q.size()); end
        for (int k = 0; k < 8; k++) begin
            pop(got, c);
            checks++; if (!got || f_re(c.data) != exp_re[k]) begin errors++; $display("FAIL basic_re[%0d]: got %0d expected %0d", k, f_re(c.data), exp_re[k]); end
            checks++; if (f_im(c.data) != 0) begin errors++; $display("FAIL basic_im[%0d]: got %0d expected 0", k, f_im(c.data)); end
            checks++; if (c.first !== (k == 0)) begin errors++; $display("FAIL basic_first[%0d]: got %b expected %b", k, c.first, k == 0); end
            if (k == 0) begin
                checks++; if (c.cyc != acc5) begin errors++; $display("FAIL basic_latency: got cycle %0d expected %0d", c.cyc, acc5); end
            end else begin
                checks++; if (c.cyc != prev + 1) begin errors++; $display("FAIL basic_stream[%0d]: got cycle %0d expected %0d", k, c.cyc, prev + 1); end
            end
            prev = c.cyc;
        end
    endtask

    task automatic test_imag;
        int   exp_im[8] = '{6, 8, 10, 12, -4, -4, -4, -4};
        cap_t c;
        logic got;
        do_reset;
        for (int i = 0; i < 8; i++) feed(0, i + 1);
        for (int i = 0; i < 4; i++) feed(0, 0);
        idle(2);
        checks++; if (cap_q.size() != 8) begin errors++; $display("FAIL imag_count: got %0d expected 8", cap_q.size()); end
        for (int k = 0; k < 8; k++) begin
            pop(got, c);
            checks++; if (!got || f_im(c.data) != exp_im[k]) begin errors++; $display("FAIL imag_im[%0d]: got %0d expected %0d", k, f_im(c.data), exp_im[k]); end
            checks++; if (f_re(c.data) != 0) begin errors++; $display("FAIL imag_re[%0d]: got %0d expected 0", k, f_re(c.data)); end
        end
    endtask

    task automatic test_wrap;
        int   in_re[8]  = '{131071, 0, 0, 0, 1, 0, 0, 0};
        int   exp_re[8] = '{-131072, 0, 0, 0, 131070, 0, 0, 0};
        cap_t c;
        logic got;
        do_reset;
        for (int i = 0; i < 8; i++) feed(in_re[i], 0);
        for (int i = 0; i < 4; i++) feed(0, 0);
        idle(2);
        checks++; if (cap_q.size() != 8) begin errors++; $display("FAIL wrap_count: got %0d expected 8", cap_q.size()); end
        for (int k = 0; k < 8; k++) begin
            pop(got, c);
            checks++; if (!got || f_re(c.data) != exp_re[k]) begin errors++; $display("FAIL wrap_re[%0d]: got %0d expected %0d", k, f_re(c.data), exp_re[k]); end
        end
    endtask

    task automatic test_stall;
        int            exp_re[8] = '{6, 8, 10, 12, -4, -4, -4, -4};
        int            acc[12];
        logic [CW-1:0] held;
        cap_t          c;
        logic          got;
        do_reset;
        for (int i = 0; i < 12; i++) begin
            feed((i < 8) ? i + 1 : 0, 0);
            acc[i] = last_acc;
            held   = bus.out_data;
            idle(1);
            if (i >= 4) begin
                checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_gap_valid[%0d]: got %b expected 0", i, bus.out_valid); end
                checks++; if (bus.out_data !== held) begin errors++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, bus.out_data, held); end
            end
        end
        idle(1);
        checks++; if (cap_q.size() != 8) begin errors++; $display("FAIL stall_count: got %0d expected 8", cap_q.size()); end
        for (int k = 0; k < 8; k++) begin
            pop(got, c);
            checks++; if (!got || f_re(c.data) != exp_re[k]) begin errors++; $display("FAIL stall_re[%0d]: got %0d expected %0d", k, f_re(c.data), exp_re[k]); end
            checks++; if (c.cyc != acc[k + 4]) begin errors++; $display("FAIL stall_cycle[%0d]: got %0d expected %0d", k, c.cyc, acc[k + 4]); end
            checks++; if (c.first !== (k == 0)) begin errors++; $display("FAIL stall_first[%0d]: got %b expected %b", k, c.first, k == 0); end
        end
    endtask

    task automatic test_back_to_back;
        int   exp_re[16] = '{6, 8, 10, 12, -4, -4, -4, -4, 24, 26, 28, 30, -4, -4, -4, -4};
        cap_t c;
        logic got;
        do_reset;
        for (int i = 0; i < 8; i++) feed(i + 1, 0);
        for (int i = 0; i < 8; i++) feed(i + 10, 0);
        for (int i = 0; i < 4; i++) feed(0, 0);
        idle(2);
        checks++; if (cap_q.size() != 16) begin errors++; $display("FAIL b2b_count: got %0d expected 16", cap_q.size()); end
        for (int k = 0; k < 16; k++) begin
            pop(got, c);
            checks++; if (!got || f_re(c.data) != exp_re[k]) begin errors++; $display("FAIL b2b_re[%0d]: got %0d expected %0d", k, f_re(c.data), exp_re[k]); end
            checks++; if (c.first !== (k == 0 || k == 8)) begin errors++; $display("FAIL b2b_first[%0d]: got %b expected %b", k, c.first, (k == 0 || k == 8)); end
        end
    endtask

    task automatic test_reset_mid_block;
        int   exp_re[8] = '{6, 8, 10, 12, -4, -4, -4, -4};
        cap_t c;
        logic got;
        do_reset;
        for (int i = 0; i < 3; i++) feed(i + 1, 0);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) feed(i + 1, 0);
        for (int i = 0; i < 4; i++) feed(0, 0);
        idle(2);
        checks++; if (cap_q.size() != 8) begin errors++; $display("FAIL midrst_count: got %0d expected 8", cap_q.size()); end
        for (int k = 0; k < 8; k++) begin
            pop(got, c);
            checks++; if (!got || f_re(c.data) != exp_re[k]) begin errors++; $display("FAIL midrst_re[%0d]: got %0d expected %0d", k, f_re(c.data), exp_re[k]); end
            checks++; if (c.first !== (k == 0)) begin errors++; $display("FAIL midrst_first[%0d]: got %b expected %b", k, c.first, k == 0); end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset;
        test_basic;
        test_imag;
        test_wrap;
        test_stall;
        test_back_to_back;
        test_reset_mid_block;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
